// File: rtl/booth_mac_seq.sv
// booth_mac_seq
//   Sequential radix-4 Booth multiply-accumulate. Retires two multiplier bits
//   per clock: SIZE/2+1 RUN cycles per product, then the result is held in
//   DONE until the consumer takes it. Operands are signed or unsigned per
//   transaction. An internal accumulator collects convolution partial sums.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake; all inputs captured on accept
//   multiplicand, multiplier SIZE-bit operands A and B
//   is_signed                1: two's complement operands, 0: unsigned
//   acc_en, acc_clr          add product into accumulator / clear it first
//   out_valid / out_ready    result handshake
//   product                  low 2*SIZE bits of A*B (exact in both modes)
//   acc_out                  accumulator value after this transaction
//   busy                     high whenever not IDLE
module booth_mac_seq #(
  parameter int SIZE      = 16,
  parameter int ACC_WIDTH = 2*SIZE+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      multiplicand,
  input  logic [SIZE-1:0]      multiplier,
  input  logic                 is_signed,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*SIZE-1:0]    product,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 busy
);

  localparam int PW    = 2*SIZE;
  localparam int NSTEP = SIZE/2 + 1;
  localparam int SW    = $clog2(NSTEP);
  localparam logic [SW-1:0] LAST = SW'(NSTEP-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        step_q, step_d;
  // Multiplicand pre-extended to the product width and shifted left by 2
  // each step, so it always holds A*4^i for the current step.
  logic [PW-1:0]        mcand_q, mcand_d;
  // {B extended to SIZE+2 bits, b[-1]=0}; shifted right by 2 each step so the
  // current Booth triplet is always bits [2:0].
  logic [SIZE+2:0]      mplr_q, mplr_d;
  logic [PW-1:0]        pp_q, pp_d;
  logic                 sgn_q, sgn_d, en_q, en_d, clr_q, clr_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                 accept;
  logic [PW-1:0]        addend, pp_sum;
  logic [ACC_WIDTH-1:0] p_sx, p_zx, p_ext, acc_base;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;
  assign acc_out   = acc_q;

  // Booth digit selection; arithmetic is modulo 2^PW which is all the
  // product output needs.
  always_comb begin
    addend = '0;
    unique case (mplr_q[2:0])
      3'b001, 3'b010: addend = mcand_q;
      3'b011:         addend = mcand_q << 1;
      3'b100:         addend = -(mcand_q << 1);
      3'b101, 3'b110: addend = -mcand_q;
      default:        addend = '0;
    endcase
  end

  assign pp_sum   = pp_q + addend;
  assign p_sx     = ACC_WIDTH'($signed(pp_sum));
  assign p_zx     = ACC_WIDTH'(pp_sum);
  assign p_ext    = sgn_q ? p_sx : p_zx;
  assign acc_base = clr_q ? '0 : acc_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    pp_d    = pp_q;
    sgn_d   = sgn_q;
    en_d    = en_q;
    clr_d   = clr_q;
    prod_d  = prod_q;
    acc_d   = acc_q;

    unique case (state_q)
      RUN: begin
        pp_d    = pp_sum;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        step_d  = step_q + SW'(1);
        if (step_q == LAST) begin
          state_d = DONE;
          prod_d  = pp_sum;
          acc_d   = en_q ? acc_base + p_ext : acc_base;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase

    // Accept from IDLE or straight out of DONE (no bubble when streaming).
    if (accept) begin
      state_d = RUN;
      step_d  = '0;
      pp_d    = '0;
      mcand_d = {{(PW-SIZE){is_signed & multiplicand[SIZE-1]}}, multiplicand};
      mplr_d  = {{2{is_signed & multiplier[SIZE-1]}}, multiplier, 1'b0};
      sgn_d   = is_signed;
      en_d    = acc_en;
      clr_d   = acc_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      pp_q    <= '0;
      sgn_q   <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      pp_q    <= pp_d;
      sgn_q   <= sgn_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Bench for booth_mac_seq (SIZE=16, ACC_WIDTH=40). Expected product/acc_out
// pairs are queued at acceptance and popped when a result is consumed.
module tb_booth_mac_seq;
  localparam int SIZE = 16;
  localparam int AW   = 40;
  localparam int N    = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SIZE-1:0]   multiplicand = '0;
  logic [SIZE-1:0]   multiplier = '0;
  logic              is_signed = 1'b0;
  logic              acc_en = 1'b0;
  logic              acc_clr = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*SIZE-1:0] product;
  logic [AW-1:0]     acc_out;
  logic              busy;

  booth_mac_seq #(.SIZE(SIZE), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .acc_out(acc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_edge = 0;
  int n_out = 0;
  logic          ov_prev = 1'b0;
  logic          rnd_done = 1'b0;
  logic [31:0]   got_p = '0;
  logic [AW-1:0] got_a = '0;
  logic [31:0]   last_p = '0;
  logic [AW-1:0] last_a = '0;
  logic [AW-1:0] mdl_acc = '0;
  logic [31:0]   exp_p_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [15:0]   corners[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: latency on each rising out_valid, scoreboard on consume.
  always @(negedge clk) begin
    if (!rst && out_valid && !ov_prev)
      chk("latency", 64'(cyc - acc_edge), 64'(N));
    ov_prev = out_valid;
    if (!rst && out_valid && out_ready) begin
      if (exp_p_q.size() == 0) begin
        chk("extra_out", 64'(exp_p_q.size()), 64'd1);
      end else begin
        got_p = product;
        got_a = acc_out;
        chk("product", 64'(product), 64'(exp_p_q.pop_front()));
        chk("acc_out", 64'(acc_out), 64'(exp_a_q.pop_front()));
        n_out++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic sg, input logic en, input logic clr);
    int k = 0;
    logic [63:0] pa, pb, pr;
    logic [31:0] p;
    logic [AW-1:0] pext, base;
    multiplicand = a; multiplier = b;
    is_signed = sg; acc_en = en; acc_clr = clr;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    pa = {{48{sg & a[15]}}, a};
    pb = {{48{sg & b[15]}}, b};
    pr = pa * pb;
    p = pr[31:0];
    pext = {{(AW-32){sg & p[31]}}, p};
    base = clr ? '0 : mdl_acc;
    mdl_acc = en ? base + pext : base;
    exp_p_q.push_back(p);
    exp_a_q.push_back(mdl_acc);
    last_p = p;
    last_a = mdl_acc;
    @(posedge clk); #1;
    acc_edge = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n0);
    int k = 0;
    while (n_out == n0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (n_out == n0) chk("out_timeout", 64'(n_out), 64'(n0 + 1));
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    if ($urandom_range(0, 3) == 0) v = corners[$urandom_range(0, 3)];
    else v = 16'($urandom_range(0, 65535));
    return v;
  endfunction

  typedef struct {
    logic [15:0] a, b;
    logic        sg, en, clr;
    logic [31:0] p;
    logic [AW-1:0] acc;
    logic        chk_acc;
    string       tag;
  } dir_t;

  dir_t dirs[8] = '{
    '{16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 32'h40000000, 40'h0, 1'b0, "s_minmin"},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001, 40'h0, 1'b0, "s_m1m1"},
    '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 32'hC0008000, 40'h0, 1'b0, "s_maxmin"},
    '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE0001, 40'h0, 1'b0, "u_ffff"},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001, 40'h0, 1'b0, "s_ffff"},
    '{16'd3,    16'd4,    1'b1, 1'b1, 1'b1, 32'd12,       40'd12, 1'b1, "acc_3x4"},
    '{16'hFFFB, 16'd6,    1'b1, 1'b1, 1'b0, 32'hFFFFFFE2, 40'hFFFFFFFFEE, 1'b1, "acc_m5x6"},
    '{16'd0,    16'd0,    1'b1, 1'b0, 1'b1, 32'd0,        40'd0, 1'b1, "acc_clr"}
  };

  initial begin
    int n0, c0, n_rnd;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed products and accumulate sequence
    for (int i = 0; i < 8; i++) begin
      n0 = n_out;
      send(dirs[i].a, dirs[i].b, dirs[i].sg, dirs[i].en, dirs[i].clr);
      wait_out(n0);
      chk(dirs[i].tag, 64'(got_p), 64'(dirs[i].p));
      if (dirs[i].chk_acc) chk({dirs[i].tag, "_acc"}, 64'(got_a), 64'(dirs[i].acc));
      @(posedge clk); #1;
    end

    // Backpressure: hold result for 5 cycles, then release with a new request
    out_ready = 1'b0;
    n0 = n_out;
    send(16'd100, 16'hFF9C, 1'b1, 1'b1, 1'b1);
    begin
      int k = 0;
      while (!out_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_prod", 64'(product), 64'hFFFFD8F0);
      chk("hold_acc", 64'(acc_out), 64'hFFFFFFD8F0);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    c0 = cyc;
    send(16'd9, 16'd11, 1'b0, 1'b1, 1'b0);
    chk("b2b_accept_edge", 64'(acc_edge), 64'(c0 + 1));
    wait_out(n0 + 1);
    chk("b2b_product", 64'(got_p), 64'd99);
    @(posedge clk); #1;

    // Reset while RUN at step 4
    send(16'd7, 16'd9, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_p_q.delete();
    exp_a_q.delete();
    mdl_acc = '0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_acc", 64'(acc_out), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    n0 = n_out;
    send(16'd2, 16'd2, 1'b1, 1'b0, 1'b0);
    wait_out(n0);
    chk("post_rst_2x2", 64'(got_p), 64'd4);
    @(posedge clk); #1;

    // Randomised streaming with output stalls
    n_rnd = n_out;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 7) == 0));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("sb_empty", 64'(exp_p_q.size()), 64'd0);
    chk("rnd_count", 64'(n_out - n_rnd), 64'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mac_seq.md
Name: booth_mac_seq

Overview:
Multi-cycle, parametrised radix-4 Booth multiply-accumulate unit for the CNN datapath. Retires 2 multiplier bits per clock, so one multiplier instance occupies far less area than a fully combinational array. Supports per-transaction signed/unsigned operands and an internal accumulator for convolution partial sums. Uses valid/ready handshakes on both input and output, so it can sit between the weight/feature fetch stage and the output buffer.

Parameters:
SIZE, 16, operand width in bits; must be even and at least 4.
ACC_WIDTH, 2*SIZE+8, accumulator and acc_out width; must be at least 2*SIZE.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand transaction offered.
in_ready  output  1  unit can accept a transaction this cycle.
multiplicand  input  SIZE  operand A.
multiplier  input  SIZE  operand B.
is_signed  input  1  1: two's-complement operands; 0: unsigned operands.
acc_en  input  1  1: add the product into the accumulator.
acc_clr  input  1  1: clear the accumulator before this transaction's add.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
product  output  2*SIZE  exact product of this transaction.
acc_out  output  ACC_WIDTH  accumulator value after this transaction.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (one clock is synchronous, active-high):
  - state goes to IDLE.
  - out_valid, busy, product, acc_out and the internal accumulator all become 0.
  - Reset applied during RUN or DONE aborts the transaction; no result is emitted.
- Input handshake: a transaction is accepted on any edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - All inputs are captured at acceptance. Later input changes have no effect on the captured transaction.
- States:
  - IDLE: on accept, go to RUN and set step counter to 0.
  - RUN: one radix-4 step per cycle. N = SIZE/2+1 steps in total (9 for SIZE=16). After step N-1, go to DONE.
  - DONE: out_valid=1.
    - out_ready && in_valid: go to RUN with the new operands (back-to-back, no idle bubble).
    - out_ready && !in_valid: go to IDLE.
    - !out_ready: hold in DONE.
- Latency: accept at edge 0; out_valid is visible after edge N. Throughput is one result per N+1 cycles when streaming.
- Arithmetic:
  - Both operands are extended to SIZE+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - Step i recodes multiplier bits (b[2i+1], b[2i], b[2i-1]) with b[-1]=0 into a digit from {-2,-1,0,+1,+2}:
    - 000, 111 -> 0
    - 001, 010 -> +1
    - 011 -> +2
    - 100 -> -2
    - 101, 110 -> -1
  - Each step adds digit·A·4^i into the partial product.
  - product = low 2*SIZE bits of the exact result; this is exact for both modes.
- Accumulate (evaluated on the RUN->DONE edge):
  - P_ext = product extended to ACC_WIDTH: sign-extended if is_signed, zero-extended otherwise.
  - base = 0 if acc_clr, else the accumulator.
  - acc_en=1: accumulator = base + P_ext.
  - acc_en=0: accumulator = base if acc_clr, else unchanged.
  - acc_out = accumulator after this update.
  - Overflow wraps modulo 2^ACC_WIDTH; no flag is raised.
- Output hold: product and acc_out stay stable while out_valid && !out_ready.
- product and acc_out are registered; they keep their last values in IDLE.
- busy = (state != IDLE).

Test Plan:
- Signed corner cases, SIZE=16, acc_en=0:
  - -32768 × -32768 -> product = 0x40000000.
  - -1 × -1 -> product = 0x00000001.
  - 32767 × -32768 -> product = 0xC0008000.
  - In every case out_valid rises exactly 9 cycles after the accept edge.
- Unsigned: 0xFFFF × 0xFFFF, is_signed=0 -> product = 0xFFFE0001. Repeat the same operands with is_signed=1 -> product = 0x00000001.
- Accumulate sequence:
  - 3×4 with acc_clr=1, acc_en=1 -> acc_out = 12.
  - -5×6 with acc_en=1 -> acc_out = -18, i.e. 0xFFFFFFFFEE in 40 bits.
  - 0×0 with acc_clr=1, acc_en=0 -> acc_out = 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, product and acc_out stay stable, in_ready=0. Then raise out_ready with in_valid=1 on the same cycle -> new transaction is accepted on that edge, and the next out_valid appears 9 cycles later.
- Reset mid-run: assert rst for one cycle at step 4 of 7×9 -> out_valid=0, acc_out=0 and in_ready=1 on the next cycle. A following 2×2 returns product = 4.
- Randomised streaming: 1000 transactions with random is_signed, acc_en and acc_clr, and random out_ready stalls -> every product and acc_out matches the reference model, and no result is dropped or duplicated.
